// File: rtl/jpeg_frame_writer.sv
// jpeg_frame_writer: packs the JPEG encoder byte stream into DATA_W-wide
// little-endian words and writes them to one of two frame buffers
// (ping-pong). Each frame ends with a flush of the partial word carrying
// byte enables, a frame_done pulse, and a report of the frame length.
// Writes beyond DEPTH_WORDS are dropped and flagged in the sticky overflow.
// Optional build macro EOI_APPEND_EN: append the 0xFF 0xD9 end-of-image
// marker to every frame through the same packer.
module jpeg_frame_writer #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 17,
    parameter int DEPTH_WORDS = 16384,
    parameter int BASE0       = 0,
    parameter int BASE1       = 16384,
    parameter int PINGPONG    = 1,
    localparam int BYTES      = DATA_W / 8,
    localparam int LB         = $clog2(BYTES),
    localparam int LEN_W      = ADDR_W + LB
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              je_valid,
    input  logic [7:0]        je_data,
    input  logic              je_done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic [BYTES-1:0]  byte_en,
    output logic              we,
    output logic              frame_done,
    output logic [LEN_W-1:0]  frame_len,
    output logic              frame_buf,
    output logic              overflow
);

    // lane counter needs at least one bit even for byte-wide memories
    localparam int LW = (LB > 0) ? LB : 1;
    // word index must be able to hold DEPTH_WORDS itself (the "full" value)
    localparam int IW = ADDR_W + 1;

`ifdef EOI_APPEND_EN
    typedef enum logic [2:0] {IDLE, RUN, EOI0, EOI1, FLUSH} state_t;
    localparam state_t END_ST = EOI0;
`else
    typedef enum logic [2:0] {IDLE, RUN, FLUSH} state_t;
    localparam state_t END_ST = FLUSH;
`endif

    state_t            state;
    logic [LW-1:0]     lane;
    logic [IW-1:0]     widx;
    logic              buf_sel;
    logic [DATA_W-1:0] acc;
    logic              done_q;

    logic              in_open;
    logic              done_hit;
    logic              take;
    logic [7:0]        in_byte;
    logic              room;
    logic              lane_last;
    logic [DATA_W-1:0] word_next;
    logic [BYTES-1:0]  part_be;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] waddr;
    logic [LEN_W-1:0]  len_now;

    // input acceptance: only IDLE/RUN take encoder bytes; a held je_done
    // counts once, on its first high cycle
    assign in_open   = (state == IDLE) || (state == RUN);
    assign done_hit  = in_open && je_done && !done_q;
    assign room      = (widx < IW'(DEPTH_WORDS));
    assign lane_last = (lane == LW'(BYTES - 1));
    assign base_addr = buf_sel ? ADDR_W'(BASE1) : ADDR_W'(BASE0);
    assign waddr     = base_addr + widx[ADDR_W-1:0];
    // bytes held so far = full words * BYTES + filled lanes
    assign len_now   = (LEN_W'(widx) << LB) + LEN_W'(lane);

    // byte source for the packer: encoder data, or the injected EOI marker
    always_comb begin
        take    = in_open && je_valid;
        in_byte = je_data;
`ifdef EOI_APPEND_EN
        if (state == EOI0) begin
            take    = 1'b1;
            in_byte = 8'hFF;
        end else if (state == EOI1) begin
            take    = 1'b1;
            in_byte = 8'hD9;
        end
`endif
    end

    // current word with the incoming byte dropped into its lane
    always_comb begin
        word_next = acc;
        word_next[8*lane +: 8] = in_byte;
    end

    // byte enables for a partial flush: lanes below the lane count
    always_comb begin
        part_be = '0;
        for (int i = 0; i < BYTES; i++) part_be[i] = (i < int'(lane));
    end

    // frame FSM, packer and registered write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lane       <= '0;
            widx       <= '0;
            buf_sel    <= 1'b0;
            acc        <= '0;
            done_q     <= 1'b0;
            addr       <= '0;
            data       <= '0;
            byte_en    <= '0;
            we         <= 1'b0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            frame_buf  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            we         <= 1'b0;
            byte_en    <= '0;
            frame_done <= 1'b0;
            done_q     <= je_done;

            if (take) begin
                if (room) begin
                    if (lane_last) begin
                        we      <= 1'b1;
                        byte_en <= '1;
                        data    <= word_next;
                        addr    <= waddr;
                        widx    <= widx + IW'(1);
                        lane    <= '0;
                        acc     <= '0;
                    end else begin
                        acc  <= word_next;
                        lane <= lane + LW'(1);
                    end
                end else begin
                    // buffer full: byte can never be written
                    overflow <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (je_valid || done_hit) overflow <= 1'b0;
                    if (done_hit)      state <= END_ST;
                    else if (je_valid) state <= RUN;
                end
                RUN: begin
                    if (done_hit) state <= END_ST;
                end
`ifdef EOI_APPEND_EN
                EOI0: begin
                    if (je_valid) overflow <= 1'b1;
                    state <= EOI1;
                end
                EOI1: begin
                    if (je_valid) overflow <= 1'b1;
                    state <= FLUSH;
                end
`endif
                FLUSH: begin
                    if (je_valid) overflow <= 1'b1;
                    // a nonzero lane count implies the word is in range
                    if (lane != '0) begin
                        we      <= 1'b1;
                        byte_en <= part_be;
                        data    <= acc;
                        addr    <= waddr;
                    end
                    frame_done <= 1'b1;
                    frame_len  <= len_now;
                    frame_buf  <= buf_sel;
                    if (PINGPONG != 0) buf_sel <= ~buf_sel;
                    widx  <= '0;
                    lane  <= '0;
                    acc   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/jpeg_frame_writer.md
Name: jpeg_frame_writer

Overview:
- Parametrised successor to jpeg_data_writer: accepts the JPEG encoder byte stream (je_valid/je_data/je_done) and packs it into DATA_W-wide memory words.
- Writes the packed words to a frame buffer, one or two buffers (ping-pong).
- Flushes the trailing partial word with byte enables and reports frame length per frame.
- Flags writes beyond the buffer depth.
- Sits between the JPEG encoder core and the frame-store RAM / host readout.

Parameters:
- DATA_W, 32, memory word width; legal 8, 16, 32, 64. BYTES = DATA_W/8 (derived).
- ADDR_W, 17, memory word-address width.
- DEPTH_WORDS, 16384, words per frame buffer; 1..2^ADDR_W.
- BASE0, 0, word base address of buffer 0.
- BASE1, 16384, word base address of buffer 1; unused when PINGPONG=0.
- PINGPONG, 1, 1 = alternate buffers per frame; 0 = always BASE0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- je_valid  in  1  je_data valid this cycle.
- je_data  in  8  encoded byte.
- je_done  in  1  one-cycle pulse, end of frame; the byte on the same cycle (if je_valid) is the last byte.
- addr  out  ADDR_W  word write address.
- data  out  DATA_W  write data.
- byte_en  out  BYTES  lane enables for the write; bit i covers data[8i+7:8i].
- we  out  1  write strobe, one cycle per word.
- frame_done  out  1  one-cycle pulse, frame complete.
- frame_len  out  ADDR_W+log2(BYTES)  bytes actually written in the last frame; held until the next frame_done.
- frame_buf  out  1  buffer index (0/1) of the last completed frame.
- overflow  out  1  sticky: bytes dropped this frame (depth exceeded, or input while flushing).

Behaviour:
- Reset values: addr=0, data=0, byte_en=0, we=0, frame_done=0, frame_len=0, frame_buf=0, overflow=0.
  - Internal: state=IDLE, lane count=0, word index=0, active buffer=0.
- Reset mid-frame discards the partial word; no write is issued.
- Packing is little-endian: the first byte of a word goes to lane 0 (data[7:0]).
- States and transitions:
  - IDLE: an accepted byte starts the frame; overflow clears and the byte goes to lane 0; go to RUN. je_done in IDLE (zero-length frame) goes directly to the end sequence.
  - RUN: each je_valid byte fills the next lane. When lane BYTES-1 is filled on edge T: at T+1, we=1, byte_en=all ones, addr=base+word index. The word index then increments and the lane count returns to 0.
  - On the edge sampling je_done: go to EOI0 if EOI_APPEND_EN is defined, else FLUSH.
  - EOI0 / EOI1: inject bytes 0xFF, then 0xD9, through the same packer, one per cycle.
  - FLUSH: on its edge, if lane count>0, issue a partial write. byte_en covers only the filled lanes; unfilled lanes of data are 0.
  - Also on the FLUSH edge: frame_done=1 for one cycle, concurrent with the partial write if any. frame_len and frame_buf update; the active buffer toggles if PINGPONG=1; return to IDLE.
- Write latency: a word write is issued the cycle after its last byte is sampled.
- There is no back-pressure; the block accepts one byte per cycle sustained.
- Overflow: when the word index reaches DEPTH_WORDS, further writes are suppressed and their bytes are not counted in frame_len. overflow=1 until the next frame starts.
- je_valid during EOI0/EOI1/FLUSH: the byte is dropped and overflow is set.
- frame_len counts both written input bytes and EOI bytes.
- je_done held high for several cycles: only the first edge counts; re-arm only in IDLE.
- addr never exceeds base+DEPTH_WORDS-1.

Optional Feature:
- Macro: EOI_APPEND_EN.
- Defined: after je_done, the bytes 0xFF, 0xD9 are appended to every frame, and frame_len includes them (+2).
- Undefined: EOI0/EOI1 do not exist; je_done goes straight to FLUSH; the stream is written verbatim.

Test Plan:
- DATA_W=32, no EOI, bytes 01..08 consecutive, je_done with byte 08:
  - Expect two writes: addr 0 data 0x04030201, then addr 1 data 0x08070605, byte_en 0xF each.
  - Expect frame_done on the cycle after the second write; frame_len=8, frame_buf=0.
- DATA_W=32, no EOI, bytes AA BB CC then je_done:
  - Expect one write data 0x00CCBBAA, byte_en 0x7, frame_done in the same cycle, frame_len=3.
- EOI_APPEND_EN, DATA_W=32, bytes 11 22, je_done:
  - Expect write 0xD9FF2211, byte_en 0xF; frame_len=4.
- PINGPONG=1, BASE1=16384, two 4-byte frames:
  - Frame 1 writes addr 0, frame_buf=0; frame 2 writes addr 16384, frame_buf=1.
- DEPTH_WORDS=2, DATA_W=32, 12 bytes:
  - Expect writes at addr 0 and 1 only; overflow=1, frame_len=8.
  - Next frame's first byte clears overflow.
- Random je_valid, reset_n low for 1 cycle mid-word:
  - Expect no we, all outputs 0; next frame restarts at addr BASE0.
- Zero-length frame (je_done only, no EOI):
  - Expect no we; frame_done pulse with frame_len=0.
